// File: rtl/wavetable_nco.sv
// ---------------------------------------------------------------------------
// wavetable_nco
//
// Numerically controlled oscillator front-end for a 16-bit sine wavetable
// BRAM that has a one-cycle registered read. On each accepted sample tick it
// advances a phase accumulator and reads the table at the top phase bits.
// It then scales the returned word by an unsigned amplitude and emits one
// signed sample together with a one-cycle valid pulse.
//
// Ports
//   nco_clk          : clock (shared with the BRAM)
//   nco_rst          : asynchronous active-high reset
//   nco_sample_tick  : one-cycle sample-rate strobe
//   nco_phase_inc    : tuning word, taken on an accepted tick
//   nco_gate         : note on/off, taken on an accepted tick
//   nco_amp          : unsigned amplitude, taken on an accepted tick
//   bram_ce          : table read enable (one-cycle pulse)
//   bram_addr        : table address
//   nco_bram_data    : table read data
//   nco_sample       : scaled signed sample, held between updates
//   nco_valid        : one-cycle pulse when nco_sample updates
//   nco_busy         : high while a sample is in flight
//   nco_overrun      : sticky, set by a tick that arrives while busy
// ---------------------------------------------------------------------------
module wavetable_nco #(
  parameter int DATA_W           = 16,
  parameter int SAMPLE_ADDR_BITS = 8,
  parameter int PHASE_W          = 24,
  parameter int AMP_W            = 8
) (
  input  logic                        nco_clk,
  input  logic                        nco_rst,
  input  logic                        nco_sample_tick,
  input  logic [PHASE_W-1:0]          nco_phase_inc,
  input  logic                        nco_gate,
  input  logic [AMP_W-1:0]            nco_amp,
  output logic                        bram_ce,
  output logic [SAMPLE_ADDR_BITS-1:0] bram_addr,
  input  logic signed [DATA_W-1:0]    nco_bram_data,
  output logic signed [DATA_W-1:0]    nco_sample,
  output logic                        nco_valid,
  output logic                        nco_busy,
  output logic                        nco_overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_SCALE = 2'd3;

  localparam int PROD_W = DATA_W + AMP_W + 1;

  // Signed data times zero-extended amplitude, then an arithmetic shift right
  // by AMP_W (truncation toward minus infinity). No saturation is needed:
  // the magnitude of the result never exceeds the input magnitude.
  function automatic logic signed [DATA_W-1:0] scale_sample(
    input logic signed [DATA_W-1:0] d,
    input logic        [AMP_W-1:0]  a
  );
    logic signed [PROD_W-1:0] d_ext;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] prod;
    d_ext = {{(AMP_W+1){d[DATA_W-1]}}, d};
    a_ext = {{(DATA_W+1){1'b0}}, a};
    prod  = d_ext * a_ext;
    return prod[DATA_W+AMP_W-1 -: DATA_W];
  endfunction

  // Control and reset-visible state
  logic [1:0]                    state_q,   state_d;
  logic [PHASE_W-1:0]            phase_q,   phase_d;
  logic                          ce_q,      ce_d;
  logic [SAMPLE_ADDR_BITS-1:0]   addr_q,    addr_d;
  logic signed [DATA_W-1:0]      sample_q,  sample_d;
  logic                          valid_q,   valid_d;
  logic                          overrun_q, overrun_d;

  // Per-sample operands; only meaningful after a tick has loaded them
  logic                          gate_q,    gate_d;
  logic [AMP_W-1:0]              amp_q,     amp_d;
  logic signed [DATA_W-1:0]      data_q,    data_d;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ce_d      = 1'b0;
    addr_d    = addr_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (nco_sample_tick && (state_q != ST_IDLE));
    gate_d    = gate_q;
    amp_d     = amp_q;
    data_d    = data_q;

    case (state_q)
      ST_IDLE: begin
        if (nco_sample_tick) begin
          gate_d  = nco_gate;
          amp_d   = nco_amp;
          state_d = ST_FETCH;
          if (nco_gate) begin
            // Read at the pre-increment phase so note-on starts at entry 0.
            addr_d  = phase_q[PHASE_W-1 -: SAMPLE_ADDR_BITS];
            ce_d    = 1'b1;
            phase_d = phase_q + nco_phase_inc;
          end else begin
            phase_d = '0;
          end
        end
      end
      // ---- stage boundary: BRAM registers its read on this edge ----
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      // ---- stage boundary: table word is valid, capture it ----
      ST_WAIT: begin
        // Gate-off still produces a (silent) sample to keep the output rate.
        data_d  = gate_q ? nco_bram_data : '0;
        state_d = ST_SCALE;
      end
      // ---- stage boundary: scale and publish ----
      ST_SCALE: begin
        sample_d = scale_sample(data_q, amp_q);
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge nco_clk or posedge nco_rst) begin
    if (nco_rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      ce_q      <= 1'b0;
      addr_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ce_q      <= ce_d;
      addr_q    <= addr_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge nco_clk) begin
    gate_q <= gate_d;
    amp_q  <= amp_d;
    data_q <= data_d;
  end

  assign bram_ce     = ce_q;
  assign bram_addr   = addr_q;
  assign nco_sample  = sample_q;
  assign nco_valid   = valid_q;
  assign nco_busy    = (state_q != ST_IDLE);
  assign nco_overrun = overrun_q;

endmodule
